// File: rtl/utc_to_unix64.sv
// Iterative proleptic-Gregorian UTC to 64-bit unix seconds converter (start/done handshake).
// Optional weekday output is enabled by defining UTC_TO_UNIX_WEEKDAY_EN.
module utc_to_unix64 #(
   parameter int MIN_YEAR = 1970
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] year,
   input  logic [3:0]  month,
   input  logic [4:0]  day,
   input  logic [4:0]  hour,
   input  logic [5:0]  minute,
   input  logic [5:0]  second,
   output logic        busy,
   output logic        done,
   output logic        err,
`ifdef UTC_TO_UNIX_WEEKDAY_EN
   output logic [2:0]  weekday,
`endif
   output logic [63:0] unix_time
);

   localparam logic [13:0] MinYear = 14'(MIN_YEAR);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_Y400, S_Y1, S_MON, S_DAYS, S_COMBINE, S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [13:0] year_q, year_d;
   logic [3:0]  month_q, month_d;
   logic [4:0]  day_q, day_d;
   logic [4:0]  hour_q, hour_d;
   logic [5:0]  min_q, min_d;
   logic [5:0]  sec_q, sec_d;
   logic [22:0] days_q, days_d;
   logic [13:0] ycur_q, ycur_d;
   logic [1:0]  r4_q, r4_d;
   logic [6:0]  r100_q, r100_d;
   logic [8:0]  r400_q, r400_d;
   logic [3:0]  mon_q, mon_d;
   logic        err_q, err_d;
   logic [63:0] unix_q, unix_d;

   function automatic logic [4:0] monthLen(input logic [3:0] m, input logic leap);
      logic [4:0] len;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
         4'd2:                    len = 5'd28 + {4'd0, leap};
         default:                 len = 5'd31;
      endcase
      return len;
   endfunction

`ifdef UTC_TO_UNIX_WEEKDAY_EN
   logic [2:0] wdacc_q, wdacc_d;
   logic [2:0] wd_q, wd_d;

   function automatic logic [2:0] mod7Add(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
   endfunction

   function automatic logic [2:0] mod7Of5(input logic [4:0] v);
      logic [4:0] t;
      if (v >= 5'd28)      t = v - 5'd28;
      else if (v >= 5'd21) t = v - 5'd21;
      else if (v >= 5'd14) t = v - 5'd14;
      else if (v >= 5'd7)  t = v - 5'd7;
      else                 t = v;
      return t[2:0];
   endfunction
`endif

   logic        leapCur;
   logic        inputsOk;
   logic [13:0] ycurPlus400;
   logic [13:0] ycurPlus1;
   logic [4:0]  curMonLen;
   logic [4:0]  targetMonLen;
   logic [63:0] days64, hour64, min64, sec64;

   // Residues always describe ycur_q; once the year loops finish they describe the target year.
   assign leapCur      = ((r4_q == 2'd0) && (r100_q != 7'd0)) || (r400_q == 9'd0);
   assign inputsOk     = (year_q >= MinYear) && (month_q >= 4'd1) && (month_q <= 4'd12) &&
                         (day_q != 5'd0) && (hour_q < 5'd24) && (min_q < 6'd60) && (sec_q < 6'd60);
   assign ycurPlus400  = ycur_q + 14'd400;
   assign ycurPlus1    = ycur_q + 14'd1;
   assign curMonLen    = monthLen(mon_q, leapCur);
   assign targetMonLen = monthLen(month_q, leapCur);
   assign days64       = {41'd0, days_q};
   assign hour64       = {59'd0, hour_q};
   assign min64        = {58'd0, min_q};
   assign sec64        = {58'd0, sec_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         year_q  <= '0;
         month_q <= '0;
         day_q   <= '0;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         days_q  <= '0;
         ycur_q  <= '0;
         r4_q    <= '0;
         r100_q  <= '0;
         r400_q  <= '0;
         mon_q   <= '0;
         err_q   <= 1'b0;
         unix_q  <= '0;
      end else begin
         state_q <= state_d;
         year_q  <= year_d;
         month_q <= month_d;
         day_q   <= day_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         days_q  <= days_d;
         ycur_q  <= ycur_d;
         r4_q    <= r4_d;
         r100_q  <= r100_d;
         r400_q  <= r400_d;
         mon_q   <= mon_d;
         err_q   <= err_d;
         unix_q  <= unix_d;
      end
   end

`ifdef UTC_TO_UNIX_WEEKDAY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdacc_q <= 3'd4;
         wd_q    <= 3'd4;
      end else begin
         wdacc_q <= wdacc_d;
         wd_q    <= wd_d;
      end
   end
`endif

   // Loop states look ahead so that a loop with zero iterations costs no cycle.
   always_comb begin
      state_d = state_q;
      year_d  = year_q;
      month_d = month_q;
      day_d   = day_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      days_d  = days_q;
      ycur_d  = ycur_q;
      r4_d    = r4_q;
      r100_d  = r100_q;
      r400_d  = r400_q;
      mon_d   = mon_q;
      err_d   = err_q;
      unix_d  = unix_q;
`ifdef UTC_TO_UNIX_WEEKDAY_EN
      wdacc_d = wdacc_q;
      wd_d    = wd_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               year_d  = year;
               month_d = month;
               day_d   = day;
               hour_d  = hour;
               min_d   = minute;
               sec_d   = second;
               err_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!inputsOk) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               days_d  = '0;
               ycur_d  = MinYear;
               r4_d    = 2'd2;
               r100_d  = 7'd70;
               r400_d  = 9'd370;
               mon_d   = 4'd1;
`ifdef UTC_TO_UNIX_WEEKDAY_EN
               wdacc_d = 3'd4;
`endif
               if ((year_q - MinYear) >= 14'd400) state_d = S_Y400;
               else if (year_q != MinYear)       state_d = S_Y1;
               else                              state_d = S_MON;
            end
         end
         S_Y400: begin
            days_d = days_q + 23'd146097;
            ycur_d = ycurPlus400;
            if ((year_q - ycurPlus400) >= 14'd400) state_d = S_Y400;
            else if (ycurPlus400 != year_q)       state_d = S_Y1;
            else                                  state_d = S_MON;
         end
         S_Y1: begin
            days_d = days_q + 23'd365 + {22'd0, leapCur};
            ycur_d = ycurPlus1;
            r4_d   = r4_q + 2'd1;
            r100_d = (r100_q == 7'd99) ? 7'd0 : r100_q + 7'd1;
            r400_d = (r400_q == 9'd399) ? 9'd0 : r400_q + 9'd1;
`ifdef UTC_TO_UNIX_WEEKDAY_EN
            wdacc_d = mod7Add(wdacc_q, {2'd0, 1'b1} + {2'd0, leapCur});
`endif
            state_d = (ycurPlus1 != year_q) ? S_Y1 : S_MON;
         end
         S_MON: begin
            // The day-of-month check rides on the first month cycle.
            if ((mon_q == 4'd1) && (day_q > targetMonLen)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (mon_q == month_q) begin
               state_d = S_DAYS;
            end else begin
               days_d = days_q + {18'd0, curMonLen};
               mon_d  = mon_q + 4'd1;
`ifdef UTC_TO_UNIX_WEEKDAY_EN
               wdacc_d = mod7Add(wdacc_q, 3'(curMonLen - 5'd28));
`endif
            end
         end
         S_DAYS: begin
            days_d = days_q + {18'd0, day_q - 5'd1};
`ifdef UTC_TO_UNIX_WEEKDAY_EN
            wdacc_d = mod7Add(wdacc_q, mod7Of5(day_q - 5'd1));
`endif
            state_d = S_COMBINE;
         end
         S_COMBINE: begin
            // 86400 = 2^16+2^14+2^12+2^8+2^7, 3600 = 2^11+2^10+2^9+2^4, 60 = 2^5+2^4+2^3+2^2
            unix_d = (days64 << 16) + (days64 << 14) + (days64 << 12) + (days64 << 8) + (days64 << 7) +
                     (hour64 << 11) + (hour64 << 10) + (hour64 << 9) + (hour64 << 4) +
                     (min64 << 5) + (min64 << 4) + (min64 << 3) + (min64 << 2) + sec64;
`ifdef UTC_TO_UNIX_WEEKDAY_EN
            wd_d = wdacc_q;
`endif
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign unix_time = unix_q;
`ifdef UTC_TO_UNIX_WEEKDAY_EN
   assign weekday   = wd_q;
`endif

endmodule

// File: tb/tb_utc_to_unix64.sv
// Directed testbench for utc_to_unix64: scoreboard of expected results popped on done.
// Weekday checks are compiled in when UTC_TO_UNIX_WEEKDAY_EN is defined.
module tb_utc_to_unix64;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [13:0] year;
   logic [3:0]  month;
   logic [4:0]  day;
   logic [4:0]  hour;
   logic [5:0]  minute;
   logic [5:0]  second;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] unix_time;
`ifdef UTC_TO_UNIX_WEEKDAY_EN
   logic [2:0]  weekday;
`endif

   typedef struct {
      string       tag;
      logic        err;
      logic [63:0] t;
      logic [2:0]  wd;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   asserts  = 0;
   int   failures = 0;
   int   cnt      = 0;

   utc_to_unix64 #(.MIN_YEAR(1970)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .year      (year),
      .month     (month),
      .day       (day),
      .hour      (hour),
      .minute    (minute),
      .second    (second),
      .busy      (busy),
      .done      (done),
      .err       (err),
`ifdef UTC_TO_UNIX_WEEKDAY_EN
      .weekday   (weekday),
`endif
      .unix_time (unix_time)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      asserts++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cnt++;
   endtask

   task automatic driveStart(input int y, input int mo, input int d, input int h, input int mi, input int s);
      @(negedge clk);
      year   = 14'(y);
      month  = 4'(mo);
      day    = 5'(d);
      hour   = 5'(h);
      minute = 6'(mi);
      second = 6'(s);
      start  = 1'b1;
      @(negedge clk);
      cnt    = 1;
      start  = 1'b0;
      year   = 14'($urandom);
      month  = 4'($urandom);
      day    = 5'($urandom);
      hour   = 5'($urandom);
      minute = 6'($urandom);
      second = 6'($urandom);
   endtask

   task automatic applyStimulus(input string tag, input int y, input int mo, input int d,
                                input int h, input int mi, input int s, input logic expErr,
                                input logic [63:0] expT, input logic [2:0] expWd, input int lat);
      exp_t e;
      e.tag = tag;
      e.err = expErr;
      e.t   = expT;
      e.wd  = expWd;
      e.lat = lat;
      sb.push_back(e);
      driveStart(y, mo, d, h, mi, s);
   endtask

   task automatic popResult();
      exp_t e;
      bit   seen;
      while (done !== 1'b1 && cnt < 600) tick();
      seen = (done === 1'b1);
      e = sb.pop_front();
      checkOutput({e.tag, " done seen"}, 64'(seen), 64'd1);
      if (seen) begin
         checkOutput({e.tag, " err"}, 64'(err), 64'(e.err));
         checkOutput({e.tag, " unix_time"}, unix_time, e.t);
`ifdef UTC_TO_UNIX_WEEKDAY_EN
         checkOutput({e.tag, " weekday"}, 64'(weekday), 64'(e.wd));
`endif
         checkOutput({e.tag, " busy low at done"}, 64'(busy), 64'd0);
         if (e.lat >= 0) checkOutput({e.tag, " latency"}, 64'(cnt), 64'(e.lat));
         tick();
         checkOutput({e.tag, " done one cycle"}, 64'(done), 64'd0);
      end
   endtask

   task automatic countDones(input int n, output int dones);
      dones = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (done === 1'b1) dones++;
      end
   endtask

   int extra;

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      year   = '0;
      month  = '0;
      day    = '0;
      hour   = '0;
      minute = '0;
      second = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset err", 64'(err), 64'd0);
      checkOutput("reset unix_time", unix_time, 64'd0);
`ifdef UTC_TO_UNIX_WEEKDAY_EN
      checkOutput("reset weekday", 64'(weekday), 64'd4);
`endif
      rst = 1'b0;

      applyStimulus("epoch", 1970, 1, 1, 0, 0, 0, 1'b0, 64'd0, 3'd4, 5);
      checkOutput("busy after start", 64'(busy), 64'd1);
      popResult();

      applyStimulus("2000-02-29", 2000, 2, 29, 12, 34, 56, 1'b0, 64'd951827696, 3'd2, 36);
      popResult();

      applyStimulus("2038 rollover", 2038, 1, 19, 3, 14, 8, 1'b0, 64'd2147483648, 3'd2, 73);
      repeat (5) tick();
      year   = 14'd1970;
      month  = 4'd1;
      day    = 5'd1;
      hour   = 5'd0;
      minute = 6'd0;
      second = 6'd0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      popResult();
      countDones(80, extra);
      checkOutput("start while busy ignored", 64'(extra), 64'd0);

      applyStimulus("2100-03-01", 2100, 3, 1, 0, 0, 0, 1'b0, 64'd4107542400, 3'd1, 137);
      popResult();

      applyStimulus("2370-01-01", 2370, 1, 1, 0, 0, 0, 1'b0, 64'd12622780800, 3'd4, 6);
      popResult();

      applyStimulus("2023-02-29 bad day", 2023, 2, 29, 0, 0, 0, 1'b1, 64'd12622780800, 3'd4, 56);
      popResult();
      applyStimulus("1969 bad year", 1969, 6, 1, 0, 0, 0, 1'b1, 64'd12622780800, 3'd4, 2);
      popResult();
      applyStimulus("hour 24", 2020, 5, 5, 24, 0, 0, 1'b1, 64'd12622780800, 3'd4, 2);
      popResult();

      driveStart(2300, 1, 1, 0, 0, 0);
      repeat (20) tick();
      checkOutput("busy mid Y1", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid reset busy", 64'(busy), 64'd0);
      checkOutput("mid reset done", 64'(done), 64'd0);
      checkOutput("mid reset unix_time", unix_time, 64'd0);
`ifdef UTC_TO_UNIX_WEEKDAY_EN
      checkOutput("mid reset weekday", 64'(weekday), 64'd4);
`endif
      @(negedge clk);
      rst = 1'b0;
      countDones(400, extra);
      checkOutput("no done after abort", 64'(extra), 64'd0);

      applyStimulus("after reset", 2000, 2, 29, 12, 34, 56, 1'b0, 64'd951827696, 3'd2, 36);
      popResult();

      $display("[TB] directed sequence complete");
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
